button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage that turns two raw, asynchronous pushbutton inputs into the clean 2-bit gesture code `ain` consumed by the downstream Moore gesture FSM. Each button is synchronised and debounced. A short chord window then merges near-simultaneous presses into one code (`11`) rather than a `01`→`11` sequence. The code is held until both buttons are released, then `ain` returns to `00`, which the downstream FSM treats as the gesture terminator.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a button must differ from its debounced value before that value flips; must be ≥1.
- `CHORD_CYCLES`, default 8: window, in cycles, for collecting a second button after the first; must be ≥1.
- `clk`  in  1  single system clock; all flops on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge of `clk`.
- `btn`  in  2  raw button levels; asynchronous and bouncy; bit0 and bit1 are independent.
- `ain`  out  2  registered gesture code to the downstream FSM; `00` when idle.
- `code_stb`  out  1  registered one-cycle pulse, asserted in the cycle `ain` first takes a new nonzero code.

## Operation
- Synchroniser, per bit: two flops, `sync1` then `sync2`.
- Debounce, per bit:
  - Counter width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync2` equals `deb`, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `deb` takes the value of `sync2` and the counter clears.
  - Any bounce shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- Gesture FSM states:
  - **IDLE** (`ain=00`): if `deb` is not `00`, go to CHORD with `acc<=deb` and `cnt<=0`.
  - **CHORD** (`ain=00`): compute `accn = acc | deb`.
    - Exit to HOLD with `ain<=accn` and `code_stb<=1` if any of the following holds: `accn==11`, `deb==00` (tap shorter than the window), or `cnt==CHORD_CYCLES-1`.
    - Otherwise `acc<=accn` and `cnt<=cnt+1`.
  - **HOLD**: `ain` is held at the latched code. Presses arriving after the window are ignored.
    - If `deb==00`, go to IDLE with `ain<=00`.
    - HOLD lasts at least 1 cycle.
- `code_stb` is asserted only on the CHORD→HOLD transition; it is 0 in all other cycles.
- `ain` never goes directly from one nonzero code to another; at least one `00` cycle always separates gestures.
- Counter `cnt` has width `$clog2(CHORD_CYCLES)` (minimum 1). It never wraps, because the exit is forced at `CHORD_CYCLES-1`.
- Unused state encodings return to IDLE with `ain=00`.

## Timing
- Reset values: `ain=00`, `code_stb=0`, state IDLE, and `sync1`, `sync2`, `deb`, `acc` and all counters at 0.
- Reset applies on the edge regardless of state. Reset mid-HOLD drops `ain` to `00` on that edge.
- After reset releases with buttons still held, `deb` re-qualifies through the normal debounce path.
- Debounce latency: if `btn` is stable from the sample at edge k, `deb` changes at edge k+DEBOUNCE_CYCLES+1.
- Press latency, with `deb` going nonzero at edge t:
  - CHORD is entered at t+1.
  - Single button held: `ain`/`code_stb` update at edge t+1+CHORD_CYCLES.
  - Both buttons' `deb` rising together: update at t+2.
- Release latency: `deb` reaching `00` at edge r gives `ain=00` at edge r+1.
- Simultaneous events are resolved in this priority order: reset first, then `accn==11`, then `deb==00`, then window expiry.

## Test plan
Parameters `DEBOUNCE_CYCLES=4`, `CHORD_CYCLES=8`; k is the first edge sampling the new `btn`.
1. `btn=01` from k, held 30 cycles, then released at edge r → `deb[0]=1` at k+5; `ain=01` and `code_stb=1` for exactly one cycle at k+14; `ain=00` at r+6.
2. `btn[1]` high for 3 cycles, then low → `deb`, `ain` and `code_stb` stay 0 throughout.
3. `btn=11` from k → `ain=11` with a single `code_stb` at k+7; no `01` or `10` code ever appears.
4. Staggered chord: `btn[0]` at k, `btn[1]` at k+4 → `ain=11` at k+10. Repeat with `btn[1]` at k+20 → `ain=01` at k+14, staying `01` with no second strobe until both buttons are released.
5. Short tap: `btn=10` sampled high only at edges k..k+5 → `ain=10` and `code_stb` at k+12; `ain=00` at k+13.
6. `reset` pulsed for one cycle while in HOLD with `btn=11` held → `ain=00` on that edge. After release, `ain=11` reappears with one strobe at reset-release edge + 7 (the full debounce and chord path restarts).

Source files
------------

// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronises and debounces two raw buttons, merges
// near-simultaneous presses into one gesture code, and holds it until release.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CHORD_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn,
   output logic [1:0] ain,
   output logic       code_stb
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CHORD_LAST = CW'(CHORD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHORD = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [DW-1:0] deb_cnt [2];

   state_t        state;
   logic [1:0]    acc;
   logic [1:0]    accn;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; cleared on reset so a held button re-qualifies.
   // NOTE: every sequential block uses non-blocking assignments so that
   // sync2 samples the pre-edge value of sync1, not the one just written.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: deb flips only after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // NOTE: the combinational merge has no branches, so nothing can be
   // left unassigned and no latch can appear.
   always_comb accn = acc | deb;

   // Gesture FSM. Exit priority out of CHORD: full chord, early release,
   // then window expiry -- all three take the same action, so one test.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         acc      <= '0;
         cnt      <= '0;
         ain      <= '0;
         code_stb <= 1'b0;
      end else begin
         code_stb <= 1'b0;
         case (state)
            S_IDLE: begin
               ain <= '0;
               if (deb != 2'b00) begin
                  state <= S_CHORD;
                  acc   <= deb;
                  cnt   <= '0;
               end
            end
            S_CHORD: begin
               if (accn == 2'b11 || deb == 2'b00 || cnt == CHORD_LAST) begin
                  state    <= S_HOLD;
                  ain      <= accn;
                  code_stb <= 1'b1;
               end else begin
                  acc <= accn;
                  cnt <= cnt + CW'(1);
               end
            end
            S_HOLD: begin
               // Late presses are ignored; only full release ends the gesture.
               if (deb == 2'b00) begin
                  state <= S_IDLE;
                  ain   <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               ain   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DEBOUNCE_CYCLES=4, CHORD_CYCLES=8.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn;
   logic [1:0] ain;
   logic       code_stb;

   int         checks   = 0;
   int         failures = 0;
   int         stb_cnt;
   logic [3:0] seen;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CHORD_CYCLES   (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn),
      .ain     (ain),
      .code_stb(code_stb)
   );

   always #5 clk = ~clk;

   // Advance n edges, sampling 1 time unit after each; tallies strobes and codes seen.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (code_stb) stb_cnt++;
         seen[ain] = 1'b1;
      end
   endtask

   task automatic clear_mon();
      stb_cnt = 0;
      seen    = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      clear_mon();
      reset = 1'b1;
      btn   = 2'b00;
      run(3);
      chk("reset_ain", 32'(ain), 32'h0);
      chk("reset_stb", 32'(code_stb), 32'h0);
      reset = 1'b0;
      run(5);

      // 1: single button, full chord window, then release
      btn = 2'b01;
      clear_mon();
      run(14);
      chk("t1_pre_ain", 32'(ain), 32'h0);
      chk("t1_pre_stb", 32'(stb_cnt), 32'h0);
      run(1);
      chk("t1_ain", 32'(ain), 32'h1);
      chk("t1_stb", 32'(code_stb), 32'h1);
      run(1);
      chk("t1_stb_drop", 32'(code_stb), 32'h0);
      chk("t1_hold_ain", 32'(ain), 32'h1);
      run(14);
      btn = 2'b00;
      run(6);
      chk("t1_rel_pre", 32'(ain), 32'h1);
      run(1);
      chk("t1_rel_ain", 32'(ain), 32'h0);
      chk("t1_stb_total", 32'(stb_cnt), 32'h1);
      run(4);

      // 2: glitch shorter than the debounce window
      clear_mon();
      btn = 2'b10;
      run(3);
      btn = 2'b00;
      run(20);
      chk("t2_stb", 32'(stb_cnt), 32'h0);
      chk("t2_seen", 32'(seen), 32'h1);

      // 3: true simultaneous chord
      clear_mon();
      btn = 2'b11;
      run(7);
      chk("t3_pre_ain", 32'(ain), 32'h0);
      run(1);
      chk("t3_ain", 32'(ain), 32'h3);
      chk("t3_stb", 32'(code_stb), 32'h1);
      run(20);
      btn = 2'b00;
      run(10);
      chk("t3_end_ain", 32'(ain), 32'h0);
      chk("t3_stb_total", 32'(stb_cnt), 32'h1);
      chk("t3_seen", 32'(seen), 32'h9);

      // 4a: staggered chord inside the window
      clear_mon();
      btn = 2'b01;
      run(4);
      btn = 2'b11;
      run(6);
      chk("t4a_pre_ain", 32'(ain), 32'h0);
      run(1);
      chk("t4a_ain", 32'(ain), 32'h3);
      chk("t4a_stb", 32'(code_stb), 32'h1);
      btn = 2'b00;
      run(10);
      chk("t4a_end_ain", 32'(ain), 32'h0);
      chk("t4a_seen", 32'(seen), 32'h9);

      // 4b: second button after the window is ignored until full release
      clear_mon();
      btn = 2'b01;
      run(14);
      chk("t4b_pre_ain", 32'(ain), 32'h0);
      run(1);
      chk("t4b_ain", 32'(ain), 32'h1);
      chk("t4b_stb", 32'(code_stb), 32'h1);
      run(5);
      btn = 2'b11;
      run(20);
      chk("t4b_late_ain", 32'(ain), 32'h1);
      btn = 2'b10;
      run(10);
      chk("t4b_half_rel", 32'(ain), 32'h1);
      chk("t4b_stb_total", 32'(stb_cnt), 32'h1);
      btn = 2'b00;
      run(10);
      chk("t4b_end_ain", 32'(ain), 32'h0);

      // 5: short tap exits the window early
      clear_mon();
      btn = 2'b10;
      run(6);
      btn = 2'b00;
      run(6);
      chk("t5_pre_ain", 32'(ain), 32'h0);
      run(1);
      chk("t5_ain", 32'(ain), 32'h2);
      chk("t5_stb", 32'(code_stb), 32'h1);
      run(1);
      chk("t5_rel_ain", 32'(ain), 32'h0);
      chk("t5_rel_stb", 32'(code_stb), 32'h0);
      run(5);

      // 6: reset during HOLD with both buttons held
      btn = 2'b11;
      run(8);
      chk("t6_first_ain", 32'(ain), 32'h3);
      run(3);
      reset = 1'b1;
      run(1);
      chk("t6_rst_ain", 32'(ain), 32'h0);
      chk("t6_rst_stb", 32'(code_stb), 32'h0);
      reset = 1'b0;
      clear_mon();
      run(7);
      chk("t6_pre_ain", 32'(ain), 32'h0);
      run(1);
      chk("t6_ain", 32'(ain), 32'h3);
      chk("t6_stb", 32'(code_stb), 32'h1);
      btn = 2'b00;
      run(10);
      chk("t6_end_ain", 32'(ain), 32'h0);
      chk("t6_stb_total", 32'(stb_cnt), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
